// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and glyph table for the seven-segment digit driver
package seven_seg_pkg;

    typedef enum logic {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_t;

    // Glyphs are stored active-high as {g,f,e,d,c,b,a}; polarity is applied by the decoder.
    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage

// File: rtl/seven_seg_digit_driver_hex_to_seg.sv
// rtl/seven_seg_digit_driver_hex_to_seg.sv - combinational nibble to seven-segment glyph decoder
module hex_to_seg
    import seven_seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    logic [6:0] glyph;

    assign glyph = blank_i ? SEG_OFF : HEX_GLYPH[nibble_i];
    assign seg_o = ACTIVE_LOW ? ~glyph : glyph;

endmodule

// File: rtl/seven_seg_digit_driver.sv
// rtl/seven_seg_digit_driver.sv - 4-digit scan sequencer with frame-synchronous value update,
// inter-digit blanking gap and optional leading-zero suppression
module seven_seg_digit_driver
    import seven_seg_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYC      = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_dp,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        blank_lz,
    output logic [1:0]  sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK_CYC - 1);
    localparam logic [6:0]    SEG_IDLE  = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     sel_q, sel_d;
    logic [15:0]    disp_q, disp_d;
    logic [3:0]     dpreg_q, dpreg_d;
    logic [19:0]    shadow_q, shadow_d;
    logic           pending_q, pending_d;
    logic [6:0]     seg_q, seg_d;
    logic           dp_q, dp_d;
    logic           frame_start_q, frame_start_d;

    logic           wrap;
    logic           accept;
    logic           lz_blank;
    logic [3:0]     nibble;
    logic [3:0]     shamt;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q + CW'(1);
        sel_d         = sel_q;
        wrap          = 1'b0;
        disp_d        = disp_q;
        dpreg_d       = dpreg_q;
        shadow_d      = shadow_q;
        pending_d     = pending_q;

        case (state_q)
            SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                    sel_d   = sel_q + 2'd1;
                    wrap    = (sel_q == 2'd3);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = GAP;
                cnt_d   = '0;
            end
        endcase

        // Accept needs pending=0 and commit needs pending=1, so they never collide.
        accept = in_valid && !pending_q;
        if (wrap && pending_q) begin
            disp_d    = shadow_q[15:0];
            dpreg_d   = shadow_q[19:16];
            pending_d = 1'b0;
        end
        if (accept) begin
            shadow_d  = {in_dp, in_data};
            pending_d = 1'b1;
        end
        frame_start_d = wrap;
    end

    // Output pattern is derived from next-state values so seg/dp line up with sel.
    assign shamt    = {sel_d, 2'b00};
    assign nibble   = disp_d[shamt +: 4];
    assign lz_blank = blank_lz && (sel_d != 2'd0) && ((disp_d >> shamt) == 16'h0000);

    hex_to_seg #(
        .ACTIVE_LOW (SEG_ACTIVE_LOW)
    ) u_hex_to_seg (
        .nibble_i (nibble),
        .blank_i  ((state_d == GAP) || lz_blank),
        .seg_o    (seg_d)
    );

    assign dp_d = ((state_d == SHOW) && dpreg_d[sel_d]) ^ SEG_ACTIVE_LOW;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= GAP;
            cnt_q         <= '0;
            sel_q         <= 2'd0;
            disp_q        <= 16'h0000;
            dpreg_q       <= 4'h0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            seg_q         <= SEG_IDLE;
            dp_q          <= SEG_ACTIVE_LOW;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sel_q         <= sel_d;
            disp_q        <= disp_d;
            dpreg_q       <= dpreg_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign in_ready    = !pending_q;
    assign sel         = sel_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// tb/tb_seven_seg_digit_driver.sv - self-checking bench for seven_seg_digit_driver
module tb_seven_seg_digit_driver;

    localparam int S = 4;
    localparam int B = 2;
    localparam int P = S + B;
    localparam int F = 4 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] in_data = 16'h0000;
    logic [3:0]  in_dp = 4'h0;
    logic        in_valid = 1'b0;
    logic        blank_lz = 1'b0;
    logic        in_ready;
    logic [1:0]  sel;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    // Model: edges since reset, committed value, shadow and pending flag.
    int          k;
    logic [15:0] m_disp;
    logic [3:0]  m_dp;
    logic [19:0] m_shadow;
    logic        m_pend;
    logic        last_acc;

    // Active-low glyphs {g,f,e,d,c,b,a}
    logic [6:0] glyph_al [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    seven_seg_digit_driver #(
        .SCAN_DIV       (S),
        .BLANK_CYC      (B),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_dp       (in_dp),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .blank_lz    (blank_lz),
        .sel         (sel),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at k=%0d", tag, obs, exp, k);
        end
    endtask

    task automatic model_reset();
        k        = 0;
        m_disp   = 16'h0000;
        m_dp     = 4'h0;
        m_shadow = '0;
        m_pend   = 1'b0;
        last_acc = 1'b0;
    endtask

    task automatic check_outputs(input logic wrap);
        int          d;
        logic        gap;
        logic [15:0] upper;
        logic [6:0]  exp_seg;
        logic        exp_dp;
        d     = (k / P) % 4;
        gap   = (k % P) < B;
        upper = m_disp >> (4 * d);
        if (gap) exp_seg = 7'h7F;
        else if (blank_lz && d != 0 && upper == 16'h0000) exp_seg = 7'h7F;
        else exp_seg = glyph_al[upper[3:0]];
        exp_dp = gap ? 1'b1 : !m_dp[d];
        chk("sel", {14'd0, sel}, 16'(d));
        chk("seg", {9'd0, seg}, {9'd0, exp_seg});
        chk("dp", {15'd0, dp}, {15'd0, exp_dp});
        chk("frame_start", {15'd0, frame_start}, {15'd0, wrap});
        chk("in_ready", {15'd0, in_ready}, {15'd0, !m_pend});
    endtask

    task automatic step();
        logic acc;
        logic wrap;
        @(posedge clk);
        acc  = in_valid && !m_pend;
        k++;
        wrap = (k % F) == 0;
        if (wrap && m_pend) begin
            m_disp = m_shadow[15:0];
            m_dp   = m_shadow[19:16];
            m_pend = 1'b0;
        end
        if (acc) begin
            m_shadow = {in_dp, in_data};
            m_pend   = 1'b1;
        end
        last_acc = acc;
        #1;
        check_outputs(wrap);
    endtask

    task automatic run_to(input int t);
        int n = 0;
        do begin
            step();
            n++;
        end while ((k % F) != t && n < 2 * F);
    endtask

    task automatic load(input logic [15:0] data, input logic [3:0] dps);
        int n = 0;
        in_data  = data;
        in_dp    = dps;
        in_valid = 1'b1;
        do begin
            step();
            n++;
        end while (!last_acc && n < 2 * F);
        in_valid = 1'b0;
        chk("load_accepted_ready_low", {15'd0, in_ready}, 16'd0);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_sel", {14'd0, sel}, 16'd0);
        chk("rst_seg", {9'd0, seg}, 16'h7F);
        chk("rst_dp", {15'd0, dp}, 16'd1);
        chk("rst_frame_start", {15'd0, frame_start}, 16'd0);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
        #6;
        rst_n = 1'b1;

        // Free-running scan with the reset value on display
        repeat (2 * F + 2) step();

        // Mid-frame load, then a second value held while the first is pending
        load(16'h1234, 4'b0001);
        in_data  = 16'hABCD;
        in_dp    = 4'b1010;
        in_valid = 1'b1;
        begin
            int n = 0;
            do begin
                step();
                n++;
            end while (!last_acc && n < 3 * F);
        end
        in_valid = 1'b0;
        chk("second_accept_after_commit", 16'(k % F), 16'd1);
        repeat (2 * F) step();

        // Valid arriving exactly on the wrap edge with nothing pending
        run_to(F - 1);
        in_data  = 16'h5678;
        in_dp    = 4'b0100;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("wrap_edge_accept_ready_low", {15'd0, in_ready}, 16'd0);
        repeat (2 * F + 3) step();

        // Leading-zero blanking
        blank_lz = 1'b1;
        load(16'h0050, 4'b1000);
        repeat (2 * F) step();
        load(16'h0000, 4'b0000);
        repeat (2 * F) step();
        load(16'h0F00, 4'b0110);
        repeat (2 * F) step();

        // Randomized traffic, holding data stable until accepted
        repeat (500) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) == 0);
                in_data  = 16'($urandom);
                in_dp    = 4'($urandom);
            end
            blank_lz = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0;

        // Asynchronous reset mid-SHOW on digit 2 with a value pending
        run_to(0);
        in_data  = 16'hBEEF;
        in_dp    = 4'hF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        run_to(2 * P + B + 1);
        chk("pending_before_reset", {15'd0, in_ready}, 16'd0);
        chk("sel_before_reset", {14'd0, sel}, 16'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", {14'd0, sel}, 16'd0);
        chk("async_rst_seg", {9'd0, seg}, 16'h7F);
        chk("async_rst_dp", {15'd0, dp}, 16'd1);
        chk("async_rst_frame_start", {15'd0, frame_start}, 16'd0);
        chk("async_rst_in_ready", {15'd0, in_ready}, 16'd1);
        #3;
        model_reset();
        rst_n = 1'b1;
        blank_lz = 1'b0;
        repeat (2 * F) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
